// File: rtl/fir_pkg.sv
// Shared command/state encodings and filter coefficients for the sequential FIR MAC.
package fir_pkg;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_LOAD    = 2'b01,
        OP_COMPUTE = 2'b10,
        OP_READ    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_STORE,
        ST_DONE
    } state_e;

    localparam int MAX_TAPS = 16;

    // Sized for the largest tap count; entries past the active count are never read.
    localparam logic signed [31:0] COEF [MAX_TAPS] = '{
        32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd5, 32'sd4, 32'sd3,
        32'sd2, 32'sd1, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0
    };

endpackage

// File: rtl/fir_mac_unit.sv
// Multiply-accumulate datapath: 32x32 signed product into a 64-bit accumulator.
// With FIR_SATURATE_EN defined the result is clamped to the signed 32-bit range, else it wraps.
module fir_mac_unit (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic signed [31:0] i_coef,
    input  logic signed [31:0] i_sample,
    output logic signed [31:0] o_result
);

    logic signed [63:0] r_acc;
    logic signed [63:0] w_prod;

    // Low 64 bits of the product are identical for signed and sign-extended unsigned operands.
    assign w_prod = {{32{i_coef[31]}}, i_coef} * {{32{i_sample[31]}}, i_sample};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod;
        end
    end

`ifdef FIR_SATURATE_EN
    localparam logic signed [63:0] MAX32 = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] MIN32 = 64'shFFFF_FFFF_8000_0000;

    always_comb begin
        if (r_acc > MAX32) begin
            o_result = 32'sh7FFF_FFFF;
        end else if (r_acc < MIN32) begin
            o_result = 32'sh8000_0000;
        end else begin
            o_result = r_acc[31:0];
        end
    end
`else
    logic w_unused_hi;

    assign w_unused_hi = ^r_acc[63:32];
    assign o_result    = r_acc[31:0];
`endif

endmodule

// File: rtl/fir_seq_mac.sv
// Sequential FIR filter: load a sample block, run one MAC per cycle, then read results back.
// Build with FIR_SATURATE_EN to clamp stored results instead of wrapping them.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for a load or compute command
// ST_LOAD  | writing samples into the sample buffer
// ST_MAC   | one multiply-accumulate per cycle over taps i = 0..n-1
// ST_STORE | write accumulator into result[k], advance k or finish
// ST_DONE  | result buffer complete, readout enabled
module fir_seq_mac
    import fir_pkg::*;
#(
    parameter int n           = 10,
    parameter int signalCount = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic signed [31:0] x,
    input  logic [1:0]         operation,
    output logic signed [31:0] y,
    output logic               done
);

    localparam int SW = (signalCount > 1) ? $clog2(signalCount) : 1;
    localparam int TW = (n > 1) ? $clog2(n) : 1;
    localparam int CW = (SW > TW) ? SW : TW;
    localparam logic [31:0]   NS     = 32'(signalCount);
    localparam logic [SW-1:0] K_LAST = SW'(signalCount - 1);
    localparam logic [TW-1:0] I_LAST = TW'(n - 1);

    state_e             r_state;
    logic [SW-1:0]      r_k;
    logic [TW-1:0]      r_i;
    logic signed [31:0] r_sample [signalCount];
    logic signed [31:0] r_result [signalCount];

    op_e                w_op;
    logic               w_addr_ok;
    logic               w_tap_valid;
    logic               w_acc_clr;
    logic               w_acc_en;
    logic [CW-1:0]      w_k_ext;
    logic [CW-1:0]      w_i_ext;
    logic [SW-1:0]      w_sidx;
    logic signed [31:0] w_coef;
    logic signed [31:0] w_sample;
    logic signed [31:0] w_mac_result;

    assign w_op        = op_e'(operation);
    assign w_addr_ok   = addr < NS;
    assign w_k_ext     = CW'(r_k);
    assign w_i_ext     = CW'(r_i);
    assign w_tap_valid = w_k_ext >= w_i_ext;
    assign w_sidx      = SW'(w_k_ext - w_i_ext);
    assign w_coef      = COEF[4'(r_i)];
    // Taps reaching before the start of the block see zero samples.
    assign w_sample    = w_tap_valid ? r_sample[w_sidx] : '0;
    assign w_acc_en    = (r_state == ST_MAC);
    assign w_acc_clr   = (r_state == ST_STORE) ||
                         (((r_state == ST_IDLE) || (r_state == ST_LOAD)) && (w_op == OP_COMPUTE));

    fir_mac_unit u_mac (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (w_acc_clr),
        .i_en     (w_acc_en),
        .i_coef   (w_coef),
        .i_sample (w_sample),
        .o_result (w_mac_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            done    <= 1'b0;
            y       <= '0;
            r_k     <= '0;
            r_i     <= '0;
            for (int j = 0; j < signalCount; j++) begin
                r_sample[j] <= '0;
                r_result[j] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_op == OP_LOAD) begin
                        r_state <= ST_LOAD;
                        if (w_addr_ok) r_sample[addr[SW-1:0]] <= x;
                    end else if (w_op == OP_COMPUTE) begin
                        r_state <= ST_MAC;
                        r_k     <= '0;
                        r_i     <= '0;
                    end
                end
                ST_MAC: begin
                    if (r_i == I_LAST) r_state <= ST_STORE;
                    else               r_i     <= r_i + 1'b1;
                end
                ST_STORE: begin
                    r_result[r_k] <= w_mac_result;
                    r_i           <= '0;
                    if (r_k == K_LAST) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    if (w_op == OP_LOAD) begin
                        r_state <= ST_LOAD;
                        done    <= 1'b0;
                        if (w_addr_ok) r_sample[addr[SW-1:0]] <= x;
                    end else if (w_op == OP_READ) begin
                        y <= w_addr_ok ? r_result[addr[SW-1:0]] : '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Randomized self-checking bench for fir_seq_mac against a plain-arithmetic FIR model.
`timescale 1ns/1ps
module tb_fir_seq_mac;

    localparam int NT = 10;
    localparam int NS = 10;
    localparam int LATENCY = NS * (NT + 1);
    localparam longint H [NT] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1};

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        addr = '0;
    logic signed [31:0] x = '0;
    logic [1:0]         operation = 2'b00;
    logic signed [31:0] y;
    logic               done;

    int vectors = 0;
    int errors  = 0;

    logic signed [31:0] m_x [NS];
    logic [31:0]        m_y [NS];

    fir_seq_mac #(.n(NT), .signalCount(NS)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .x         (x),
        .operation (operation),
        .y         (y),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_compute;
        for (int k = 0; k < NS; k++) begin
            longint acc;
            acc = 0;
            for (int i = 0; i < NT; i++)
                if (k - i >= 0) acc += H[i] * longint'(m_x[k - i]);
`ifdef FIR_SATURATE_EN
            if (acc > 64'sd2147483647)        m_y[k] = 32'h7FFF_FFFF;
            else if (acc < -64'sd2147483648)  m_y[k] = 32'h8000_0000;
            else                              m_y[k] = acc[31:0];
`else
            m_y[k] = acc[31:0];
`endif
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        operation = 2'b00;
        addr = '0;
        x = '0;
        repeat (2) tick();
        reset = 1'b0;
        for (int j = 0; j < NS; j++) m_x[j] = '0;
        tick();
    endtask

    // Out-of-range dummy write first so no sample depends on the entry cycle.
    task automatic load_block;
        operation = 2'b01;
        addr = 32'(NS + 5);
        x = 32'h5A5A_5A5A;
        tick();
        for (int j = 0; j < NS; j++) begin
            addr = 32'(j);
            x = m_x[j];
            tick();
        end
        operation = 2'b00;
    endtask

    task automatic run_compute(input bit scramble, output int lat);
        operation = 2'b10;
        addr = $urandom;
        x = $urandom;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            tick();
            if (done === 1'b1) begin
                lat = c - 1;
                break;
            end
            if (scramble) begin
                operation = 2'($urandom);
                addr = $urandom;
                x = $urandom;
            end
        end
        operation = 2'b00;
    endtask

    task automatic read_at(input int a, output logic [31:0] v);
        operation = 2'b11;
        addr = 32'(a);
        tick();
        v = y;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        do_reset();
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++;
        if (y !== 32'd0) begin errors++; $display("FAIL reset_y: got %h want 0", y); end
        read_at(0, v);
        vectors++;
        if (v !== 32'd0 || done !== 1'b0) begin
            errors++; $display("FAIL read_before_done: y %h done %b want 0 0", v, done);
        end
        operation = 2'b00;
    endtask

    task automatic test_impulse;
        int lat;
        logic [31:0] v;
        for (int j = 0; j < NS; j++) m_x[j] = (j == 0) ? 32'sd1 : 32'sd0;
        load_block();
        model_compute();
        run_compute(1'b0, lat);
        vectors++;
        if (lat !== LATENCY) begin errors++; $display("FAIL impulse_latency: got %0d want %0d", lat, LATENCY); end
        for (int k = 0; k < NS; k++) begin
            read_at(k, v);
            vectors++;
            if (v !== m_y[k]) begin errors++; $display("FAIL impulse_y[%0d]: got %h want %h", k, v, m_y[k]); end
        end
        operation = 2'b00;
    endtask

    task automatic test_step;
        int lat;
        logic [31:0] v, y_before;
        for (int j = 0; j < NS; j++) m_x[j] = 32'sd1;
        load_block();
        model_compute();
        y_before = y;
        run_compute(1'b1, lat);
        vectors++;
        if (lat !== LATENCY) begin errors++; $display("FAIL step_latency: got %0d want %0d", lat, LATENCY); end
        vectors++;
        if (y !== y_before) begin errors++; $display("FAIL y_hold_during_compute: got %h want %h", y, y_before); end
        for (int k = 0; k < NS; k++) begin
            read_at(k, v);
            vectors++;
            if (v !== m_y[k]) begin errors++; $display("FAIL step_y[%0d]: got %h want %h", k, v, m_y[k]); end
        end
        read_at(3, v);
        vectors++;
        if (v !== m_y[3]) begin errors++; $display("FAIL readout_addr3: got %h want %h", v, m_y[3]); end
        read_at(NS + 2, v);
        vectors++;
        if (v !== 32'd0) begin errors++; $display("FAIL readout_out_of_range: got %h want 0", v); end
        read_at(NS - 1, v);
        operation = 2'b00;
        addr = $urandom;
        repeat (3) tick();
        vectors++;
        if (y !== m_y[NS - 1] || done !== 1'b1) begin
            errors++; $display("FAIL y_hold_idle: y %h done %b want %h 1", y, done, m_y[NS - 1]);
        end
    endtask

    task automatic test_random_blocks;
        int lat, a;
        logic [31:0] v;
        for (int it = 0; it < 3; it++) begin
            operation = 2'b01;
            addr = 32'(NS + 7);
            x = $urandom;
            tick();
            for (int w = 0; w < 25; w++) begin
                a = $urandom_range(0, NS + 6);
                addr = 32'(a);
                if (it == 0) x = 32'($urandom_range(0, 2000)) - 32'd1000;
                else         x = $urandom;
                if (a < NS) m_x[a] = x;
                tick();
            end
            model_compute();
            run_compute(1'b1, lat);
            vectors++;
            if (lat !== LATENCY) begin errors++; $display("FAIL random%0d_latency: got %0d want %0d", it, lat, LATENCY); end
            for (int r = 0; r < 12; r++) begin
                a = $urandom_range(0, NS + 3);
                read_at(a, v);
                vectors++;
                if (v !== ((a < NS) ? m_y[a] : 32'd0)) begin
                    errors++; $display("FAIL random%0d_y[%0d]: got %h want %h", it, a, v, (a < NS) ? m_y[a] : 32'd0);
                end
            end
            operation = 2'b00;
        end
    endtask

    task automatic test_overflow;
        int lat;
        logic [31:0] v;
        for (int j = 0; j < NS; j++) m_x[j] = 32'sh7FFF_FFFF;
        load_block();
        model_compute();
        run_compute(1'b0, lat);
        vectors++;
        if (lat !== LATENCY) begin errors++; $display("FAIL overflow_latency: got %0d want %0d", lat, LATENCY); end
        for (int k = 0; k < NS; k++) begin
            read_at(k, v);
            vectors++;
            if (v !== m_y[k]) begin errors++; $display("FAIL overflow_y[%0d]: got %h want %h", k, v, m_y[k]); end
        end
        read_at(NS - 1, v);
        vectors++;
`ifdef FIR_SATURATE_EN
        if (v !== 32'h7FFF_FFFF) begin errors++; $display("FAIL overflow_last_sat: got %h want 7fffffff", v); end
`else
        if (v !== 32'hFFFF_FFE2) begin errors++; $display("FAIL overflow_last_wrap: got %h want ffffffe2", v); end
`endif
        operation = 2'b00;
    endtask

    task automatic test_reset_mid_compute;
        int lat;
        logic [31:0] v;
        for (int j = 0; j < NS; j++) m_x[j] = 32'sd1;
        load_block();
        operation = 2'b10;
        repeat (51) tick();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (done !== 1'b0 || y !== 32'd0) begin
            errors++; $display("FAIL reset_mid_compute: done %b y %h want 0 0", done, y);
        end
        operation = 2'b00;
        tick();
        reset = 1'b0;
        for (int j = 0; j < NS; j++) m_x[j] = '0;
        repeat (5) tick();
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_after_abort: got %b want 0", done); end
        for (int j = 0; j < NS; j++) m_x[j] = 32'sd1;
        load_block();
        model_compute();
        run_compute(1'b0, lat);
        vectors++;
        if (lat !== LATENCY) begin errors++; $display("FAIL recompute_latency: got %0d want %0d", lat, LATENCY); end
        for (int k = 0; k < NS; k++) begin
            read_at(k, v);
            vectors++;
            if (v !== m_y[k]) begin errors++; $display("FAIL recompute_y[%0d]: got %h want %h", k, v, m_y[k]); end
        end
        operation = 2'b00;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [31:0] v;
        operation = 2'b01;
        addr = 32'(NS + 3);
        x = $urandom;
        tick();
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL reload_clears_done: got %b want 0", done); end
        for (int j = 0; j < NS; j++) m_x[j] = 32'($urandom_range(0, 200000)) - 32'd100000;
        load_block();
        model_compute();
        run_compute(1'b1, lat);
        vectors++;
        if (lat !== LATENCY) begin errors++; $display("FAIL reload_latency: got %0d want %0d", lat, LATENCY); end
        for (int k = NS - 1; k >= 0; k--) begin
            read_at(k, v);
            vectors++;
            if (v !== m_y[k]) begin errors++; $display("FAIL reload_y[%0d]: got %h want %h", k, v, m_y[k]); end
        end
        operation = 2'b00;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_random_blocks();
        test_overflow();
        test_reset_mid_compute();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
